// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
//
// Purpose: groups both requester handshakes and the unified memory port into one bundle.
// Modports:
//    master - requester/memory side: drives req*, we*, addr*, wdata*, lock*, mem_rd_data;
//             observes gnt*, rvalid*, rdata*, mem_addr, mem_wr_data, mem_wr_ena
//    slave  - arbiter side: the reverse directions
interface mem_port_arbiter_if #(
   parameter int N      = 32,
   parameter int ADDR_W = 32
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [N-1:0]      wdata0;
   logic              lock0;
   logic              gnt0;
   logic              rvalid0;
   logic [N-1:0]      rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [N-1:0]      wdata1;
   logic              lock1;
   logic              gnt1;
   logic              rvalid1;
   logic [N-1:0]      rdata1;

   logic [ADDR_W-1:0] mem_addr;
   logic [N-1:0]      mem_wr_data;
   logic              mem_wr_ena;
   logic [N-1:0]      mem_rd_data;

   modport master (
      output req0, we0, addr0, wdata0, lock0,
      output req1, we1, addr1, wdata1, lock1,
      output mem_rd_data,
      input  gnt0, rvalid0, rdata0,
      input  gnt1, rvalid1, rdata1,
      input  mem_addr, mem_wr_data, mem_wr_ena
   );

   modport slave (
      input  req0, we0, addr0, wdata0, lock0,
      input  req1, we1, addr1, wdata1, lock1,
      input  mem_rd_data,
      output gnt0, rvalid0, rdata0,
      output gnt1, rvalid1, rdata1,
      output mem_addr, mem_wr_data, mem_wr_ena
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a single unified memory port
//
// Purpose: shares one synchronous memory port between requester 0 (CPU) and requester 1
// (DMA/debug loader). Round-robin on ties, bounded locked bursts, one-cycle read return.
// Ports:
//    clk   - clock, rising edge
//    rst_n - synchronous reset, active-low
//    bus   - mem_port_arbiter_if.slave: req/gnt handshakes, read return, memory port
// Configuration macro: MEM_PORT_ARB_FIXED_PRIO_EN (defined: port 0 always wins a tie)
module mem_port_arbiter #(
   parameter int N        = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_LOCK = 8
) (
   input logic             clk,
   input logic             rst_n,
   mem_port_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(MAX_LOCK);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_t;

   owner_t            owner, owner_nxt;
   logic              last, last_nxt;
   logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
   logic [1:0]        rd_pend, rd_pend_nxt;

   logic              gnt0, gnt1;
   logic              hold0, hold1;
   logic              lock_keep0, lock_keep1;
   logic [ADDR_W-1:0] addr_mux;
   logic [N-1:0]      wdata_mux;
   logic              wr_ena_mux;
   logic              tie_pick1;

   // Grants are gated by rst_n so nothing is accepted while reset is being applied,
   // even though the owner register only clears at the next edge.
   assign hold0 = (owner == OWN_P0) && bus.req0;
   assign hold1 = (owner == OWN_P1) && bus.req1;
   assign gnt0  = rst_n && hold0;
   assign gnt1  = rst_n && hold1;

   // A lock only extends the tenure while the beat budget is not exhausted; the final
   // beat falls through to the unlocked rules so a waiting port gets in.
   assign lock_keep0 = hold0 && bus.lock0 && (lock_cnt < LOCK_LAST);
   assign lock_keep1 = hold1 && bus.lock1 && (lock_cnt < LOCK_LAST);

`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
   assign tie_pick1 = 1'b0;
`else
   // Round-robin uses the winner including this cycle's beat, so a contended
   // unlocked owner hands over right after its beat.
   assign tie_pick1 = ~last_nxt;
`endif

   always_comb begin
      owner_nxt    = owner;
      last_nxt     = last;
      lock_cnt_nxt = '0;
      rd_pend_nxt  = {gnt1 && !bus.we1, gnt0 && !bus.we0};
      addr_mux     = '0;
      wdata_mux    = '0;
      wr_ena_mux   = 1'b0;

      if (gnt0) begin
         addr_mux   = bus.addr0;
         wdata_mux  = bus.wdata0;
         wr_ena_mux = bus.we0;
         last_nxt   = 1'b0;
      end else if (gnt1) begin
         addr_mux   = bus.addr1;
         wdata_mux  = bus.wdata1;
         wr_ena_mux = bus.we1;
         last_nxt   = 1'b1;
      end

      if (lock_keep0 || lock_keep1) begin
         owner_nxt    = owner;
         lock_cnt_nxt = lock_cnt + 1'b1;
      end else if ((hold0 && !bus.req1) || (hold1 && !bus.req0)) begin
         owner_nxt = owner;
      end else if (bus.req0 && bus.req1) begin
         owner_nxt = tie_pick1 ? OWN_P1 : OWN_P0;
      end else if (bus.req0) begin
         owner_nxt = OWN_P0;
      end else if (bus.req1) begin
         owner_nxt = OWN_P1;
      end else begin
         owner_nxt = OWN_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner    <= OWN_NONE;
         last     <= 1'b1;
         lock_cnt <= '0;
         rd_pend  <= 2'b00;
      end else begin
         owner    <= owner_nxt;
         last     <= last_nxt;
         lock_cnt <= lock_cnt_nxt;
         rd_pend  <= rd_pend_nxt;
      end
   end

   // Pending read returns are dropped while reset is asserted.
   assign bus.gnt0        = gnt0;
   assign bus.gnt1        = gnt1;
   assign bus.rvalid0     = rst_n && rd_pend[0];
   assign bus.rvalid1     = rst_n && rd_pend[1];
   assign bus.rdata0      = (rst_n && rd_pend[0]) ? bus.mem_rd_data : '0;
   assign bus.rdata1      = (rst_n && rd_pend[1]) ? bus.mem_rd_data : '0;
   assign bus.mem_addr    = addr_mux;
   assign bus.mem_wr_data = wdata_mux;
   assign bus.mem_wr_ena  = wr_ena_mux;

endmodule
